param_sync_fifo: RTL and testbench

Parametrised single-clock FIFO for buffering feature-map and weight words between the line-buffer and systolic-array stages of the CNN datapath. It generalises the team's 8x32 FIFO in data width and depth. It adds simultaneous read/write, an exact occupancy count, programmable almost-full and almost-empty flags, a registered read with a valid strobe, flush, and sticky overflow/underflow error flags.

---
 rtl/param_sync_fifo.sv | 78 +++++++
 tb/tb_param_sync_fifo.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with occupancy count, threshold flags,
// registered read with valid strobe, flush and sticky error flags.
module param_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    input  logic                        EN,
    input  logic                        FLUSH,
    input  logic                        WR,
    input  logic [DATA_WIDTH-1:0]       dataIn,
    input  logic                        RD,
    output logic [DATA_WIDTH-1:0]       dataOut,
    output logic                        dataValid,
    output logic [$clog2(DEPTH):0]      COUNT,
    output logic                        EMPTY,
    output logic                        FULL,
    output logic                        ALMOST_FULL,
    output logic                        ALMOST_EMPTY,
    output logic                        OVERFLOW,
    output logic                        UNDERFLOW
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         rd_ptr, wr_ptr;
    logic                  rd_ok, wr_ok, active;

    assign EMPTY        = COUNT == '0;
    assign FULL         = COUNT == CW'(DEPTH);
    assign ALMOST_FULL  = int'(COUNT) >= AF_LEVEL;
    assign ALMOST_EMPTY = int'(COUNT) <= AE_LEVEL;

    // A read frees a slot, so a write into a full FIFO succeeds when paired with a read
    assign active = Rst_n && EN && !FLUSH;
    assign rd_ok  = RD && !EMPTY;
    assign wr_ok  = WR && (!FULL || rd_ok);

    always_ff @(posedge Clk)
        if (active && wr_ok)
            mem[wr_ptr] <= dataIn;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            COUNT     <= '0;
            dataOut   <= '0;
            dataValid <= 1'b0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else if (!EN) begin
            dataValid <= 1'b0;
        end else if (FLUSH) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            COUNT     <= '0;
            dataValid <= 1'b0;
        end else begin
            dataValid <= rd_ok;
            if (rd_ok) begin
                dataOut <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            COUNT <= COUNT + CW'(wr_ok) - CW'(rd_ok);
            if (WR && FULL && !RD)
                OVERFLOW <= 1'b1;
            if (RD && EMPTY)
                UNDERFLOW <= 1'b1;
        end
    end
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: directed vector table plus hand-written wrap/full/empty sequences.
module tb_param_sync_fifo;
    logic        Clk = 1'b0;
    logic        Rst_n, EN, FLUSH, WR, RD;
    logic [31:0] dataIn, dataOut;
    logic        dataValid, EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;
    logic [3:0]  COUNT;

    int tests = 0;
    int fails = 0;

    param_sync_fifo #(.DATA_WIDTH(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .EN(EN), .FLUSH(FLUSH), .WR(WR), .dataIn(dataIn),
        .RD(RD), .dataOut(dataOut), .dataValid(dataValid), .COUNT(COUNT), .EMPTY(EMPTY),
        .FULL(FULL), .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
        .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          rst_n, en, fl, wr, rd;
        logic [31:0] din;
        int          cnt;
        bit          vld;
        logic [31:0] dout;
        bit          ovf, unf;
    } vec_t;

    vec_t tbl[$];
    logic [31:0] q[$];
    logic [31:0] e;

    function automatic vec_t v(bit rst_n, bit en, bit fl, bit wr, bit rd, logic [31:0] din,
                               int cnt, bit vld, logic [31:0] dout, bit ovf, bit unf);
        vec_t t;
        t.rst_n = rst_n; t.en = en; t.fl = fl; t.wr = wr; t.rd = rd; t.din = din;
        t.cnt = cnt; t.vld = vld; t.dout = dout; t.ovf = ovf; t.unf = unf;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit rst_n, input bit en, input bit fl, input bit wr, input bit rd,
                       input logic [31:0] din);
        @(negedge Clk);
        Rst_n = rst_n; EN = en; FLUSH = fl; WR = wr; RD = rd; dataIn = din;
        @(posedge Clk);
        #1;
    endtask

    task automatic apply(input int i, input vec_t t);
        cyc(t.rst_n, t.en, t.fl, t.wr, t.rd, t.din);
        chk($sformatf("v%0d COUNT", i), 32'(COUNT), 32'(t.cnt));
        chk($sformatf("v%0d dataValid", i), 32'(dataValid), 32'(t.vld));
        chk($sformatf("v%0d dataOut", i), dataOut, t.dout);
        chk($sformatf("v%0d EMPTY", i), 32'(EMPTY), 32'(t.cnt == 0));
        chk($sformatf("v%0d FULL", i), 32'(FULL), 32'(t.cnt == 8));
        chk($sformatf("v%0d ALMOST_FULL", i), 32'(ALMOST_FULL), 32'(t.cnt >= 6));
        chk($sformatf("v%0d ALMOST_EMPTY", i), 32'(ALMOST_EMPTY), 32'(t.cnt <= 2));
        chk($sformatf("v%0d OVERFLOW", i), 32'(OVERFLOW), 32'(t.ovf));
        chk($sformatf("v%0d UNDERFLOW", i), 32'(UNDERFLOW), 32'(t.unf));
    endtask

    initial begin
        Rst_n = 1'b0; EN = 1'b1; FLUSH = 1'b0; WR = 1'b0; RD = 1'b0; dataIn = '0;
        // reset held for two edges
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // fill 0x100..0x107, then overflow write, stepping COUNT 0..8
        for (int i = 0; i < 8; i++)
            tbl.push_back(v(1, 1, 0, 1, 0, 32'h100 + i, i + 1, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 1, 0, 32'hDEAD, 8, 0, 0, 1, 0));
        // drain, COUNT 8..0
        for (int i = 0; i < 8; i++)
            tbl.push_back(v(1, 1, 0, 0, 1, 0, 7 - i, 1, 32'h100 + i, 1, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 32'h107, 1, 0));
        // reset, then RD&WR on empty
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 1, 1, 32'h55, 1, 0, 0, 0, 1));
        tbl.push_back(v(1, 1, 0, 0, 1, 0, 0, 1, 32'h55, 0, 1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(1, 1, 0, 1, 0, 32'h200 + i, i + 1, 0, 32'h55, 0, 1));
        // EN=0 freezes, FLUSH clears count but keeps sticky flags
        tbl.push_back(v(1, 0, 0, 1, 0, 32'h999, 4, 0, 32'h55, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 4, 0, 32'h55, 0, 1));
        tbl.push_back(v(1, 1, 1, 1, 1, 32'h777, 0, 0, 32'h55, 0, 1));
        tbl.push_back(v(1, 1, 0, 1, 0, 32'h300, 1, 0, 32'h55, 0, 1));
        tbl.push_back(v(1, 1, 0, 0, 1, 0, 0, 1, 32'h300, 0, 1));
        tbl.push_back(v(1, 1, 0, 0, 1, 0, 0, 0, 32'h300, 0, 1));
        foreach (tbl[i]) apply(i, tbl[i]);

        // wrap-around with sustained simultaneous RD&WR at COUNT=5
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 0, 1, 0, 32'h400 + i);
            q.push_back(32'h400 + i);
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 0, 1, 1, 32'h500 + i);
            q.push_back(32'h500 + i);
            e = q.pop_front();
            chk($sformatf("wrap%0d COUNT", i), 32'(COUNT), 5);
            chk($sformatf("wrap%0d dataValid", i), 32'(dataValid), 1);
            chk($sformatf("wrap%0d dataOut", i), dataOut, e);
        end
        chk("wrap OVERFLOW", 32'(OVERFLOW), 0);
        chk("wrap UNDERFLOW", 32'(UNDERFLOW), 0);

        // RD&WR while full keeps COUNT at 8 and appends 0xAA at the tail
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 1, 0, 32'h600 + i);
            q.push_back(32'h600 + i);
        end
        chk("full COUNT", 32'(COUNT), 8);
        cyc(1, 1, 0, 1, 1, 32'hAA);
        q.push_back(32'hAA);
        e = q.pop_front();
        chk("fullrw COUNT", 32'(COUNT), 8);
        chk("fullrw OVERFLOW", 32'(OVERFLOW), 0);
        chk("fullrw dataOut", dataOut, e);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 0, 0, 1, 0);
            e = q.pop_front();
            chk($sformatf("drain%0d dataOut", i), dataOut, e);
        end
        chk("last dataOut", dataOut, 32'hAA);
        chk("drained EMPTY", 32'(EMPTY), 1);
        cyc(1, 1, 0, 0, 0, 0);
        chk("idle dataValid", 32'(dataValid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
